// File: rtl/spill_fill_dma_engine.sv
// Round-robin multi-channel AXI4 burst DMA for buffer spill (write) / fill (read).
// Optional SFDE_RESP_CHECK_EN: sticky per-channel error on non-OKAY bresp/rresp.
module spill_fill_dma_engine #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [NUM_CH-1:0]          cmd_valid,
  output logic [NUM_CH-1:0]          cmd_ready,
  input  logic [NUM_CH-1:0]          cmd_write,
  input  logic [NUM_CH*ADDR_W-1:0]   cmd_addr,
  input  logic [NUM_CH*LEN_W-1:0]    cmd_len,
  input  logic [NUM_CH*DATA_W-1:0]   wr_data,
  input  logic [NUM_CH-1:0]          wr_valid,
  output logic [NUM_CH-1:0]          wr_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_CH-1:0]          rd_valid,
  input  logic [NUM_CH-1:0]          rd_ready,
  output logic                       rd_last,
  output logic [NUM_CH-1:0]          done,
  output logic [NUM_CH-1:0]          err,
  output logic                       busy,
  output logic [ADDR_W-1:0]          m_axi_awaddr,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [DATA_W-1:0]          m_axi_wdata,
  output logic [DATA_W/8-1:0]        m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,
  output logic [ADDR_W-1:0]          m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DATA_W-1:0]          m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic              aw_v;
  logic              ar_v;
  logic [NUM_CH-1:0] done_q;

  logic              gnt_hit;
  logic [CH_W-1:0]   gnt_idx;
  logic              accept;
  logic [NUM_CH-1:0] gnt_oh;
  logic [CH_W-1:0]   nxt_ptr;
  logic [7:0]        axlen;

  logic              in_wd;
  logic              in_rd;
  logic              in_wr;
  logic              wv_sel;
  logic              rr_sel;
  logic [DATA_W-1:0] wd_sel;
  logic              w_hs;
  logic              w_end;
  logic              b_hs;
  logic              r_hs;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_hit = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_hit && cmd_valid[idx]) begin
        gnt_hit = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
  end

  // No accept in the done cycle, so IDLE always lasts at least one cycle.
  assign accept    = (state == S_IDLE) && !(|done_q) && !areset && gnt_hit;
  assign cmd_ready = accept ? (NUM_CH'(1) << gnt_idx) : '0;

  assign gnt_oh  = NUM_CH'(1) << gnt_q;
  assign nxt_ptr = (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    axlen = '0;
    axlen[LEN_W-1:0] = len_q;
  end

  assign in_wd  = (state == S_WR_DATA);
  assign in_rd  = (state == S_RD_DATA);
  assign in_wr  = (state == S_WR_RESP);
  assign wv_sel = wr_valid[gnt_q];
  assign rr_sel = rd_ready[gnt_q];
  assign wd_sel = wr_data[gnt_q*DATA_W +: DATA_W];

  assign w_end = (beat_cnt == len_q);
  assign w_hs  = in_wd && wv_sel && m_axi_wready;
  assign b_hs  = in_wr && m_axi_bvalid;
  assign r_hs  = in_rd && m_axi_rvalid && rr_sel;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = axlen;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = aw_v;

  assign m_axi_wdata  = wd_sel;
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = in_wd && w_end;
  assign m_axi_wvalid = in_wd && wv_sel;
  assign wr_ready     = (in_wd && m_axi_wready) ? gnt_oh : '0;
  assign m_axi_bready = in_wr;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = axlen;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = ar_v;

  assign rd_data      = m_axi_rdata;
  assign rd_valid     = (in_rd && m_axi_rvalid) ? gnt_oh : '0;
  assign rd_last      = in_rd && m_axi_rlast;
  assign m_axi_rready = in_rd && rr_sel;

  assign done = done_q;
  assign busy = (state != S_IDLE);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      aw_v     <= 1'b0;
      ar_v     <= 1'b0;
      done_q   <= '0;
    end else begin
      done_q <= '0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            gnt_q  <= gnt_idx;
            addr_q <= cmd_addr[gnt_idx*ADDR_W +: ADDR_W];
            len_q  <= cmd_len[gnt_idx*LEN_W +: LEN_W];
            if (cmd_write[gnt_idx]) begin
              state <= S_WR_ADDR;
              aw_v  <= 1'b1;
            end else begin
              state <= S_RD_ADDR;
              ar_v  <= 1'b1;
            end
          end
        end
        S_WR_ADDR: begin
          if (m_axi_awready) begin
            aw_v  <= 1'b0;
            state <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (w_hs) begin
            if (w_end) begin
              beat_cnt <= '0;
              state    <= S_WR_RESP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            state  <= S_IDLE;
            done_q <= gnt_oh;
            rr_ptr <= nxt_ptr;
          end
        end
        S_RD_ADDR: begin
          if (m_axi_arready) begin
            ar_v  <= 1'b0;
            state <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (r_hs && m_axi_rlast) begin
            state  <= S_IDLE;
            done_q <= gnt_oh;
            rr_ptr <= nxt_ptr;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SFDE_RESP_CHECK_EN
  logic [NUM_CH-1:0] err_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      err_q <= '0;
    end else if ((b_hs && m_axi_bresp != 2'b00) ||
                 (r_hs && m_axi_rresp != 2'b00)) begin
      err_q <= err_q | gnt_oh;
    end
  end

  assign err = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{m_axi_bresp, m_axi_rresp, b_hs};
  assign err = '0;
`endif

endmodule

// File: tb/tb_spill_fill_dma_engine.sv
// Directed bench for spill_fill_dma_engine (NUM_CH=4, DATA_W=64).
// Expected err depends on SFDE_RESP_CHECK_EN.
module tb_spill_fill_dma_engine;

  localparam int NC = 4;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int LW = 4;

`ifdef SFDE_RESP_CHECK_EN
  localparam logic [3:0] EXP_ERR = 4'b0001;
`else
  localparam logic [3:0] EXP_ERR = 4'b0000;
`endif

  logic              aclk = 1'b0;
  logic              areset;
  logic [NC-1:0]     cmd_valid, cmd_ready, cmd_write;
  logic [NC*AW-1:0]  cmd_addr;
  logic [NC*LW-1:0]  cmd_len;
  logic [NC*DW-1:0]  wr_data;
  logic [NC-1:0]     wr_valid, wr_ready;
  logic [DW-1:0]     rd_data;
  logic [NC-1:0]     rd_valid, rd_ready;
  logic              rd_last;
  logic [NC-1:0]     done, err;
  logic              busy;
  logic [AW-1:0]     awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic [1:0]        awburst, arburst;
  logic              awvalid, awready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wlast, wvalid, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  logic              arvalid, arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_order[6] = '{0, 1, 3, 0, 1, 3};

  always #5 aclk = ~aclk;

  spill_fill_dma_engine #(
    .NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_last(rd_last), .done(done), .err(err), .busy(busy),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic look();
    @(negedge aclk);
  endtask

  initial begin
    int beat;
    int ng;
    int stall;
    logic rv;
    logic hs;

    areset    = 1'b1;
    cmd_valid = 4'b1111;
    cmd_write = '0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_data   = '0;
    wr_valid  = '0;
    rd_ready  = '0;
    awready   = 1'b1;
    wready    = 1'b1;
    arready   = 1'b1;
    bresp     = 2'b00;
    bvalid    = 1'b0;
    rdata     = '0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    rvalid    = 1'b0;

    // 1: reset with all channels requesting
    tick();
    tick();
    look();
    chk("rst_cmd_ready", cmd_ready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_done", done, 4'b0000);
    chk("rst_err", err, 4'b0000);
    tick();
    areset    = 1'b0;
    cmd_valid = '0;
    look();
    chk("post_rst_busy", busy, 1'b0);

    // 2: ch1 spill, len 3
    tick();
    cmd_valid = 4'b0010;
    cmd_write = 4'b0010;
    cmd_addr[1*AW +: AW] = 32'h1000_0040;
    cmd_len[1*LW +: LW]  = 4'd3;
    look();
    chk("t2_cmd_ready", cmd_ready, 4'b0010);
    tick();
    cmd_valid = '0;
    look();
    chk("t2_awvalid", awvalid, 1'b1);
    chk("t2_awaddr", awaddr, 32'h1000_0040);
    chk("t2_awlen", awlen, 8'd3);
    chk("t2_awsize", awsize, 3'd3);
    chk("t2_awburst", awburst, 2'b01);
    chk("t2_busy", busy, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 4'b0010;
      wr_data[1*DW +: DW] = 64'hA0 + 64'(i);
      look();
      chk("t2_wvalid", wvalid, 1'b1);
      chk("t2_wdata", wdata, 64'hA0 + 64'(i));
      chk("t2_wlast", wlast, (i == 3));
      chk("t2_wr_ready", wr_ready, 4'b0010);
      chk("t2_wstrb", wstrb, 8'hFF);
      tick();
    end
    wr_valid = '0;
    bvalid   = 1'b1;
    look();
    chk("t2_bready", bready, 1'b1);
    chk("t2_wvalid_resp", wvalid, 1'b0);
    chk("t2_done_early", done, 4'b0000);
    tick();
    bvalid = 1'b0;
    look();
    chk("t2_done", done, 4'b0010);
    chk("t2_idle", busy, 1'b0);
    chk("t2_bready_idle", bready, 1'b0);
    tick();
    look();
    chk("t2_done_clr", done, 4'b0000);

    // 3: ch2 fill, len 7, gapped rvalid, toggling rd_ready
    tick();
    cmd_valid = 4'b0100;
    cmd_write = 4'b0000;
    cmd_addr[2*AW +: AW] = 32'h2000_0100;
    cmd_len[2*LW +: LW]  = 4'd7;
    look();
    chk("t3_cmd_ready", cmd_ready, 4'b0100);
    tick();
    cmd_valid = '0;
    look();
    chk("t3_arvalid", arvalid, 1'b1);
    chk("t3_araddr", araddr, 32'h2000_0100);
    chk("t3_arlen", arlen, 8'd7);
    chk("t3_arsize", arsize, 3'd3);
    tick();
    beat = 0;
    rv   = 1'b0;
    hs   = 1'b0;
    for (int c = 0; c < 64 && beat < 8; c++) begin
      if (!(rv && !hs)) rv = (c % 2 == 0);
      rvalid   = rv;
      rdata    = 64'hB000 + 64'(beat);
      rlast    = (beat == 7);
      rd_ready = (c % 3 != 1) ? 4'b0100 : 4'b0000;
      look();
      hs = rv && rd_ready[2];
      chk("t3_rd_valid", rd_valid, rv ? 4'b0100 : 4'b0000);
      chk("t3_rready", rready, rd_ready[2]);
      if (hs) begin
        chk("t3_rd_data", rd_data, 64'hB000 + 64'(beat));
        chk("t3_rd_last", rd_last, (beat == 7));
        beat++;
      end
      tick();
    end
    rvalid   = 1'b0;
    rlast    = 1'b0;
    rd_ready = '0;
    chk("t3_beats", beat, 8);
    look();
    chk("t3_done", done, 4'b0100);

    // 4: round-robin with 4'b1011 held
    tick();
    areset = 1'b1;
    tick();
    areset    = 1'b0;
    cmd_valid = 4'b1011;
    cmd_write = 4'b0000;
    cmd_len   = '0;
    rvalid    = 1'b1;
    rlast     = 1'b1;
    rd_ready  = 4'b1111;
    ng = 0;
    for (int c = 0; c < 80 && ng < 6; c++) begin
      look();
      if (done != 4'b0000) chk("t4_no_grant_on_done", cmd_ready, 4'b0000);
      if (cmd_ready != 4'b0000) begin
        chk("t4_grant", cmd_ready, 64'(1) << exp_order[ng]);
        ng++;
      end
      tick();
    end
    chk("t4_grant_count", ng, 6);
    cmd_valid = '0;
    for (int c = 0; c < 20; c++) begin
      look();
      if (!busy) break;
      tick();
    end
    chk("t4_drain", busy, 1'b0);
    tick();
    tick();
    rvalid   = 1'b0;
    rlast    = 1'b0;
    rd_ready = '0;

    // 5: ch3 spill, len 5, 5-cycle stall before beat 3
    cmd_valid = 4'b1000;
    cmd_write = 4'b1000;
    cmd_addr[3*AW +: AW] = 32'h3000_0000;
    cmd_len[3*LW +: LW]  = 4'd5;
    look();
    chk("t5_cmd_ready", cmd_ready, 4'b1000);
    tick();
    cmd_valid = '0;
    look();
    chk("t5_awlen", awlen, 8'd5);
    tick();
    beat  = 0;
    stall = 0;
    for (int c = 0; c < 40 && beat < 6; c++) begin
      if (beat == 2 && stall < 5) begin
        wr_valid = '0;
        stall++;
        look();
        chk("t5_stall_wvalid", wvalid, 1'b0);
        chk("t5_stall_wlast", wlast, 1'b0);
      end else begin
        wr_valid = 4'b1000;
        wr_data[3*DW +: DW] = 64'hC0 + 64'(beat);
        look();
        chk("t5_wvalid", wvalid, 1'b1);
        chk("t5_wdata", wdata, 64'hC0 + 64'(beat));
        chk("t5_wlast", wlast, (beat == 5));
        beat++;
      end
      tick();
    end
    chk("t5_beats", beat, 6);
    wr_valid = '0;
    bvalid   = 1'b1;
    look();
    chk("t5_bready", bready, 1'b1);
    tick();
    bvalid = 1'b0;
    look();
    chk("t5_done", done, 4'b1000);
    tick();

    // 6: ch0 spill len 0 with SLVERR
    cmd_valid = 4'b0001;
    cmd_write = 4'b0001;
    cmd_addr[0*AW +: AW] = 32'h0000_8000;
    cmd_len[0*LW +: LW]  = 4'd0;
    look();
    chk("t6_cmd_ready", cmd_ready, 4'b0001);
    tick();
    cmd_valid = '0;
    tick();
    wr_valid = 4'b0001;
    wr_data[0*DW +: DW] = 64'hDD;
    look();
    chk("t6_wlast_len0", wlast, 1'b1);
    chk("t6_wvalid", wvalid, 1'b1);
    tick();
    wr_valid = '0;
    bvalid   = 1'b1;
    bresp    = 2'b10;
    look();
    chk("t6_err_before_b", err, 4'b0000);
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
    look();
    chk("t6_done", done, 4'b0001);
    chk("t6_err_after_b", err, EXP_ERR);
    tick();
    cmd_valid = 4'b0010;
    cmd_write = 4'b0000;
    cmd_len[1*LW +: LW] = 4'd0;
    look();
    chk("t6_ch1_grant", cmd_ready, 4'b0010);
    tick();
    cmd_valid = '0;
    rvalid    = 1'b1;
    rlast     = 1'b1;
    rd_ready  = 4'b0010;
    tick();
    tick();
    rvalid   = 1'b0;
    rlast    = 1'b0;
    rd_ready = '0;
    look();
    chk("t6_ch1_done", done, 4'b0010);
    chk("t6_err_sticky", err, EXP_ERR);

    // reset while an AR is pending
    tick();
    cmd_valid = 4'b0100;
    cmd_len[2*LW +: LW] = 4'd3;
    arready = 1'b0;
    tick();
    cmd_valid = '0;
    look();
    chk("rst_mid_arvalid", arvalid, 1'b1);
    tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    look();
    chk("rst_mid_arvalid_drop", arvalid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_err_clr", err, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
